// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode, state and control encodings for the multicycle control unit
package riscv_pkg;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: instruction fields and flags in, datapath controls out
interface control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       we_rf;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, we_rf, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, state
  );
  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, we_rf, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, state
  );
endinterface

// File: rtl/control_fsm_alu_decoder.sv
// alu_decoder: maps alu_op and instruction function fields to an ALU control code
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);
  always_comb begin
    alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  funct3 == 3'b000    ? ((op5 && funct7b5) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010    ? ALU_SLT :
                  funct3 == 3'b110    ? ALU_OR  :
                  funct3 == 3'b111    ? ALU_AND : ALU_ADD;
  end
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle RISC-V Moore control FSM with ALU and immediate decode
module control_fsm
  import riscv_pkg::*;
(
  input logic clk,
  input logic rst_n,
  control_fsm_if.master bus
);
  state_t     state_q, state_d;
  logic       pc_update, branch, adr_src, mem_write, ir_write, we_rf;
  logic [1:0] alu_op, result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:   state_d = (bus.op == OP_LW || bus.op == OP_SW) ? S_MEMADR :
                            bus.op == OP_R   ? S_EXECUTER :
                            bus.op == OP_I   ? S_EXECUTEI :
                            bus.op == OP_BEQ ? S_BEQ :
                            bus.op == OP_JAL ? S_JAL : S_FETCH;
      S_MEMADR:   state_d = bus.op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    we_rf      = 1'b0;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        we_rf      = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNC;
      end
      S_ALUWB:    we_rf = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end
  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (alu_control)
  );
  // strobes are gated so nothing writes while reset is held
  assign bus.pc_write    = rst_n & (pc_update | (branch & bus.zero));
  assign bus.ir_write    = rst_n & ir_write;
  assign bus.we_rf       = rst_n & we_rf;
  assign bus.mem_write   = rst_n & mem_write;
  assign bus.adr_src     = adr_src;
  assign bus.result_src  = result_src;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_control = alu_control;
  assign bus.imm_src     = imm_decode(bus.op);
  assign bus.state       = state_q;
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle RISC-V control unit: a Moore main FSM plus combinational ALU and immediate decoders. It sequences every instruction through fetch, decode, execute, memory and writeback. It drives the datapath muxes, the instruction-register and PC enables, the memory write strobe, and the `we_rf` write enable of the register file directly downstream. Supported instructions are lw, sw, R-type ALU ops, I-type ALU ops, beq and jal.

## Interface
Parameters:
- none. Opcode, state and ALU encodings are fixed constants.

Ports:
- `clk` in 1: single clock. All state updates occur on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `op` in 7: opcode field, taken from the instruction register.
- `funct3` in 3: instruction bits [14:12].
- `funct7b5` in 1: instruction bit 30.
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select. 0 selects PC, 1 selects the ALU result register.
- `mem_write` out 1: data memory write strobe.
- `ir_write` out 1: instruction register and old-PC register enable.
- `we_rf` out 1: register file write enable.
- `result_src` out 2: result mux select. 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `alu_src_a` out 2: ALU operand A select. 00 = PC, 01 = old PC, 10 = rs1 register.
- `alu_src_b` out 2: ALU operand B select. 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: ALU function. 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `state` out 4: current state, for debug and the bench.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Transitions:
  - FETCH goes to DECODE.
  - DECODE branches on `op`:
    - 0000011 or 0100011 go to MEMADR.
    - 0110011 goes to EXECUTER.
    - 0010011 goes to EXECUTEI.
    - 1100011 goes to BEQ.
    - 1101111 goes to JAL.
    - Any other opcode goes to FETCH. The illegal instruction is skipped and nothing is written.
  - MEMADR goes to MEMREAD for lw and to MEMWRITE for sw.
  - MEMREAD goes to MEMWB, then to FETCH.
  - MEMWRITE goes to FETCH.
  - EXECUTER, EXECUTEI and JAL go to ALUWB, then to FETCH.
  - BEQ goes to FETCH.
- Per-state outputs. Any output not listed is 0.
  - FETCH: `ir_write`=1, `alu_src_b`=10, `result_src`=10, pc_update=1, alu_op=00.
  - DECODE: `alu_src_a`=01, `alu_src_b`=01, alu_op=00. This computes the branch/jump target.
  - MEMADR: `alu_src_a`=10, `alu_src_b`=01, alu_op=00.
  - MEMREAD: `adr_src`=1.
  - MEMWRITE: `adr_src`=1, `mem_write`=1.
  - MEMWB: `result_src`=01, `we_rf`=1.
  - EXECUTER: `alu_src_a`=10, `alu_src_b`=00, alu_op=10.
  - EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, alu_op=10.
  - ALUWB: `we_rf`=1.
  - BEQ: `alu_src_a`=10, `alu_src_b`=00, alu_op=01, branch=1.
  - JAL: `alu_src_a`=01, `alu_src_b`=10, pc_update=1.
- `pc_write` = pc_update OR (branch AND `zero`).
- ALU decoder (alu_op is internal):
  - alu_op 00 gives add. alu_op 01 gives sub.
  - alu_op 10 decodes on `funct3`:
    - 000 gives sub when `op`[5] AND `funct7b5`, otherwise add.
    - 010 gives slt, 110 gives or, 111 gives and.
    - Any other `funct3` gives add.
- `imm_src` is decoded from `op` in every state:
  - 0000011 and 0010011 give 00.
  - 0100011 gives 01.
  - 1100011 gives 10.
  - 1101111 gives 11.
  - Any other opcode gives 00.

## Timing
- Reset: `rst_n` low forces `state` to FETCH asynchronously.
  - While `rst_n`=0, the strobes `pc_write`, `ir_write`, `we_rf` and `mem_write` are held at 0.
  - While `rst_n`=0, the other outputs take their FETCH values and `alu_control` is 000.
- After reset: the first rising edge with `rst_n`=1 executes FETCH, i.e. latches the instruction and sets PC to PC+4.
- Reset asserted mid-instruction aborts the instruction immediately, with no further strobes. Any write strobed in an earlier cycle stays committed.
- Cycles per instruction, counting from FETCH through the last state:
  - lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3.
  - Illegal opcode 2 (FETCH, DECODE).
- All outputs are combinational functions of `state`, `op`, `funct3`, `funct7b5` and `zero`. There is no registered output and no extra latency.
- `zero` affects `pc_write` in BEQ only, and is sampled on the same edge.
- `we_rf` is high for exactly one cycle per lw, R-type, I-type or jal instruction. It is never high for sw, beq or an illegal opcode.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - the state encoding;
  - the ALU control codes;
  - the imm_src and result_src encodings.
- One sub-module, `alu_decoder`, with inputs alu_op, `funct3`, `op`[5] and `funct7b5`, and output `alu_control`.
- The main FSM and the immediate decode stay in `control_fsm`.

## Test plan
- Reset with `op`=0000011, then release: `state`=FETCH and all strobes 0 during reset. The following states are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. `we_rf`=1 only in MEMWB, with `result_src`=01.
- sw (`op`=0100011): the state sequence ends at MEMWRITE with `mem_write`=1 and `adr_src`=1. `imm_src`=01. `we_rf` is never 1.
- R-type sub (`op`=0110011, `funct3`=000, `funct7b5`=1): `alu_control`=001 in EXECUTER. With `funct7b5`=0 it is 000. `funct3`=111 gives 010 and `funct3`=010 gives 101.
- beq with `zero`=1: `pc_write`=1 in BEQ and the next state is FETCH. With `zero`=0, `pc_write`=0.
- jal (`op`=1101111): `pc_write`=1 in JAL, which then goes to ALUWB with `we_rf`=1. `imm_src`=11.
- Illegal `op`=1111111: DECODE returns to FETCH with no strobes. Separately, `rst_n` pulsed low during EXECUTER makes `state`=FETCH immediately, and `we_rf` never rises.
